// File: rtl/cpu7_exu_rf_mp.sv
// Multi-port integer register file with pending-write scoreboard,
// same-cycle write bypass and a post-reset clear sweep.
module cpu7_exu_rf_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 6,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic [NUM_WR-1:0]          wen,
    input  logic [NUM_WR*ADDR_W-1:0]   waddr,
    input  logic [NUM_WR*DATA_W-1:0]   wdata,
    input  logic [NUM_WR-1:0]          sb_set,
    input  logic [NUM_WR*ADDR_W-1:0]   sb_addr,
    input  logic                       sb_flush,
    output logic                       init_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]    busy;
    logic [DEPTH-1:0]    busy_nxt;
    logic [DEPTH-1:0]    set_vec;
    logic [DEPTH-1:0]    clr_vec;
    logic [NUM_WR-1:0]   wr_ok;
    logic                ready;

    assign ready = (state == READY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
                state     <= READY;
                init_done <= 1'b1;
            end
        end
    end

    // A port loses to any higher port aiming at the same entry.
    always_comb begin
        wr_ok = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_ok[j] = ready & wen[j];
            if (ZERO_REG != 0 && waddr[j*ADDR_W +: ADDR_W] == '0)
                wr_ok[j] = 1'b0;
            for (int h = 0; h < NUM_WR; h++) begin
                if (h > j && wen[h] &&
                    waddr[h*ADDR_W +: ADDR_W] == waddr[j*ADDR_W +: ADDR_W])
                    wr_ok[j] = 1'b0;
            end
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        always_ff @(posedge clk) begin
            if (!rst) begin
                if (state == INIT) begin
                    if (cnt == ADDR_W'(e))
                        regs[e] <= '0;
                end else begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (wr_ok[j] && waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(e))
                            regs[e] <= wdata[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // A newer producer's set outranks flush and completion.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (sb_set[j])
                set_vec[sb_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
            if (wen[j])
                clr_vec[waddr[j*ADDR_W +: ADDR_W]] = 1'b1;
        end
        if (sb_flush)
            busy_nxt = set_vec;
        else
            busy_nxt = (busy & ~clr_vec) | set_vec;
        if (ZERO_REG != 0)
            busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else if (ready)
            busy <= busy_nxt;
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rdata[k*DATA_W +: DATA_W] = regs[raddr[k*ADDR_W +: ADDR_W]];
            rbusy[k] = busy[raddr[k*ADDR_W +: ADDR_W]];
            for (int j = 0; j < NUM_WR; j++) begin
                if (wen[j] &&
                    waddr[j*ADDR_W +: ADDR_W] == raddr[k*ADDR_W +: ADDR_W]) begin
                    rdata[k*DATA_W +: DATA_W] = wdata[j*DATA_W +: DATA_W];
                    rbusy[k] = 1'b0;
                end
            end
            if (ZERO_REG != 0 && raddr[k*ADDR_W +: ADDR_W] == '0) begin
                rdata[k*DATA_W +: DATA_W] = '0;
                rbusy[k] = 1'b0;
            end
            if (!ready) begin
                rdata[k*DATA_W +: DATA_W] = '0;
                rbusy[k] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu7_exu_rf_mp.sv
// Directed vector bench for cpu7_exu_rf_mp: init sweep, bypass,
// write priority, zero register and scoreboard behaviour.
module tb_cpu7_exu_rf_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] raddr;
    logic [191:0] rdata;
    logic [5:0]  rbusy;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  sb_set;
    logic [9:0]  sb_addr;
    logic        sb_flush;
    logic        init_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu7_exu_rf_mp dut (
        .clk       (clk),
        .rst       (rst),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr),
        .sb_flush  (sb_flush),
        .init_done (init_done)
    );

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  sbs;
        logic [4:0]  sa0;
        logic [4:0]  sa1;
        logic        fl;
        logic [4:0]  ra;
        logic [31:0] ea;
        logic        ba;
        logic [4:0]  rb;
        logic [31:0] eb;
        logic        bb;
    } vec_t;

    vec_t tv [19];

    function automatic vec_t mk(
        logic [1:0] w, logic [4:0] a0, logic [31:0] d0,
        logic [4:0] a1, logic [31:0] d1, logic [1:0] s,
        logic [4:0] s0, logic [4:0] s1, logic f,
        logic [4:0] ra, logic [31:0] ea, logic ba,
        logic [4:0] rb, logic [31:0] eb, logic bb);
        vec_t v;
        v.wen = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
        v.sbs = s; v.sa0 = s0; v.sa1 = s1; v.fl = f;
        v.ra = ra; v.ea = ea; v.ba = ba;
        v.rb = rb; v.eb = eb; v.bb = bb;
        return v;
    endfunction

    task automatic idle();
        wen = '0; waddr = '0; wdata = '0;
        sb_set = '0; sb_addr = '0; sb_flush = 1'b0;
        raddr = '0;
    endtask

    task automatic set_rd(input logic [4:0] ra, input logic [4:0] rb);
        for (int k = 0; k < 6; k++)
            raddr[k*5 +: 5] = (k % 2 == 0) ? ra : rb;
    endtask

    task automatic chk_ports(input logic [31:0] ea, input logic ba,
                             input logic [31:0] eb, input logic bb,
                             input string tag);
        logic [31:0] ed;
        logic        eby;
        for (int k = 0; k < 6; k++) begin
            ed  = (k % 2 == 0) ? ea : eb;
            eby = (k % 2 == 0) ? ba : bb;
            n_vec++;
            if (rdata[k*32 +: 32] !== ed) begin
                n_err++;
                $display("FAIL %s rdata%0d got %h want %h",
                         tag, k, rdata[k*32 +: 32], ed);
            end
            n_vec++;
            if (rbusy[k] !== eby) begin
                n_err++;
                $display("FAIL %s rbusy%0d got %b want %b",
                         tag, k, rbusy[k], eby);
            end
        end
    endtask

    task automatic chk_init(input logic exp, input string tag);
        n_vec++;
        if (init_done !== exp) begin
            n_err++;
            $display("FAIL %s init_done got %b want %b", tag, init_done, exp);
        end
    endtask

    task automatic sweep_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            set_rd(5'(a), 5'(a));
            #1;
            chk_ports('0, 1'b0, '0, 1'b0, $sformatf("%s_r%0d", tag, a));
        end
        @(negedge clk);
        idle();
    endtask

    task automatic count_init(input string tag);
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk);
            #1;
            chk_init(e == 32, $sformatf("%s_edge%0d", tag, e));
        end
    endtask

    initial begin
        tv[0]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 0, 2'b00, 0, 0, 0,
                    5, 32'hDEADBEEF, 0, 0, 0, 0);
        tv[1]  = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0,
                    5, 32'hDEADBEEF, 0, 7, 0, 0);
        tv[2]  = mk(2'b11, 7, 32'h11, 7, 32'h22, 2'b00, 0, 0, 0,
                    7, 32'h22, 0, 5, 32'hDEADBEEF, 0);
        tv[3]  = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0,
                    7, 32'h22, 0, 5, 32'hDEADBEEF, 0);
        tv[4]  = mk(2'b01, 0, 32'hFFFFFFFF, 0, 0, 2'b01, 0, 0, 0,
                    0, 0, 0, 7, 32'h22, 0);
        tv[5]  = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0,
                    0, 0, 0, 0, 0, 0);
        tv[6]  = mk(2'b00, 0, 0, 0, 0, 2'b01, 9, 0, 0,
                    9, 0, 0, 0, 0, 0);
        tv[7]  = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0,
                    9, 0, 1, 7, 32'h22, 0);
        tv[8]  = mk(2'b10, 0, 0, 9, 3, 2'b00, 0, 0, 0,
                    9, 3, 0, 9, 3, 0);
        tv[9]  = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0,
                    9, 3, 0, 0, 0, 0);
        tv[10] = mk(2'b01, 9, 4, 0, 0, 2'b01, 9, 0, 0,
                    9, 4, 0, 0, 0, 0);
        tv[11] = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0,
                    9, 4, 1, 0, 0, 0);
        tv[12] = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1,
                    9, 4, 1, 0, 0, 0);
        tv[13] = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0,
                    9, 4, 0, 0, 0, 0);
        tv[14] = mk(2'b00, 0, 0, 0, 0, 2'b01, 9, 0, 0,
                    9, 4, 0, 0, 0, 0);
        tv[15] = mk(2'b00, 0, 0, 0, 0, 2'b10, 0, 4, 1,
                    9, 4, 1, 4, 0, 0);
        tv[16] = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0,
                    9, 4, 0, 4, 0, 1);
        tv[17] = mk(2'b11, 4, 32'hAAAA5555, 3, 32'h12345678, 2'b00, 0, 0, 0,
                    4, 32'hAAAA5555, 0, 3, 32'h12345678, 0);
        tv[18] = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0,
                    4, 32'hAAAA5555, 0, 3, 32'h12345678, 0);

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_init(1'b0, "in_reset");

        // Release with a write and a set pending; both must be ignored.
        @(negedge clk);
        rst = 1'b0;
        wen = 2'b01; waddr[4:0] = 5; wdata[31:0] = 32'h1234;
        sb_set = 2'b01; sb_addr[4:0] = 5; sb_flush = 1'b0;
        set_rd(5, 5);
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk);
            #1;
            chk_init(e == 32, $sformatf("init_edge%0d", e));
            if (e == 10)
                chk_ports('0, 1'b0, '0, 1'b0, "during_init");
            if (e == 31)
                idle();
        end
        sweep_zero("post_init");

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            wen = tv[i].wen;
            waddr = {tv[i].wa1, tv[i].wa0};
            wdata = {tv[i].wd1, tv[i].wd0};
            sb_set = tv[i].sbs;
            sb_addr = {tv[i].sa1, tv[i].sa0};
            sb_flush = tv[i].fl;
            set_rd(tv[i].ra, tv[i].rb);
            #1;
            chk_ports(tv[i].ea, tv[i].ba, tv[i].eb, tv[i].bb,
                      $sformatf("vec%0d", i));
        end
        @(negedge clk);
        idle();

        // Reset again from READY, then interrupt the sweep at cnt=10.
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_init(1'b0, "rst_ready");
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            chk_init(1'b0, $sformatf("pre_mid_edge%0d", e));
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_init(1'b0, "mid_rst");
        @(negedge clk);
        rst = 1'b0;
        count_init("mid");
        sweep_zero("post_mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
